zstr_arb: RTL and testbench
===========================

Name: zstr_arb

Overview:
- N-to-1 arbiter/multiplexer for z-stream (vld/bus/rdy) interfaces.
- Shares one downstream drain (e.g. a zstr_drn or a shared datapath) between N zstr_src requesters.
- Round-robin fairness with optional burst lock: a winner keeps the grant for up to BL consecutive transfers.
- Output is a registered pipeline stage, so the block cuts the combinational valid/bus path between requesters and the drain.

Parameters:
- N, 4, number of requesting input streams (N >= 2)
- BW, 1, bus width of each stream
- XZ, 1'bx, value driven on zo_bus while zo_vld is low (idle state)
- BL, 1, maximum consecutive transfers granted to one requester before rotation (BL >= 1)
- NW, $clog2(N), width of the requester index

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset; asynchronous, active-high
- si_vld, input, N, per-requester transfer valid
- si_bus, input, N*BW, per-requester grouped bus; requester i occupies bits [i*BW +: BW]
- si_rdy, output, N, per-requester transfer ready
- zo_vld, output, 1, output transfer valid (registered)
- zo_bus, output, BW, output grouped bus (registered)
- zo_sel, output, NW, index of the requester that produced the current zo_bus (registered)
- zo_rdy, input, 1, output transfer ready from the drain

Behaviour:
- Transfer rule, all streams: a transfer occurs on a rising clk edge when vld & rdy are both high.
- Reset (asynchronous, immediate): zo_vld=0, zo_bus=XZ, zo_sel=0, rr pointer ptr=0, state=IDLE, burst counter cnt=0.
- Reset asserted mid-operation discards the data held in the output register; no transfer completes on that edge.
- Output stage load enable: ld = ~zo_vld | zo_rdy. This gives full throughput of one transfer per cycle with no bubble.
- Grant gnt is combinational, one-hot or none:
  - IDLE: first i with si_vld[i]=1, searching ptr, ptr+1, ..., wrapping modulo N.
  - LOCK: gnt = own if si_vld[own]=1. If si_vld[own]=0, the lock is released in the same cycle and the IDLE search is used, starting at own+1.
- si_rdy[i] = ld & gnt[i]. At most one bit is high. si_rdy never depends on si_vld of another requester through a registered path.
- On a transfer from requester w (ld & si_vld[w] & gnt[w]): zo_vld<=1, zo_bus<=si_bus[w], zo_sel<=w.
- If ld=1 and there is no transfer: zo_vld<=0, zo_bus<=XZ, zo_sel holds its value.
- If ld=0: all outputs hold.
- State machine, transitions only on a transfer from w:
  - IDLE, BL=1: ptr<=w+1 mod N; stay IDLE.
  - IDLE, BL>1: enter LOCK, own<=w, cnt<=1.
  - LOCK, w==own, cnt==BL-1: go to IDLE, ptr<=own+1, cnt<=0.
  - LOCK, w==own, otherwise: cnt<=cnt+1.
  - LOCK released because si_vld[own]=0, with transfer from another w: treat as from IDLE (ptr/lock update for w).
  - LOCK released, no transfer: go to IDLE, ptr<=own+1, cnt<=0.
- ptr wraps from N-1 to 0. When N is not a power of two, the modulo is explicit.
- Latency: si transfer to zo_vld is 1 cycle. Back-pressure (zo_rdy=0 while zo_vld=1) drives all si_rdy low in the same cycle.
- Requesters must hold vld/bus stable until their transfer. The arbiter never grants a requester with vld low.

Decomposition:
- Package zstr_pkg holds:
  - the rr search function (N-wide one-hot first-set from a rotating pointer);
  - the state enum {IDLE, LOCK};
  - a helper computing NW, guarding against $clog2(1)=0.
- One natural sub-module: zstr_reg, the one-entry registered z-stream pipeline stage (vld/bus/rdy with ld = ~vld | rdy). The arbiter feeds its muxed stream into zstr_reg. zstr_reg is reusable elsewhere.

Test Plan (N=4, BW=8, BL=2, XZ=8'hxx unless noted):
- Reset, then all si_vld=0 -> zo_vld=0, zo_bus=8'hxx, si_rdy=4'b0000. Async assert of rst mid-stream -> zo_vld drops before the next clk edge.
- si_vld=4'b1111 constant, zo_rdy=1, bus_i=8'h10+i -> zo_sel sequence 0,0,1,1,2,2,3,3,0,..., one transfer per cycle, first zo_vld one cycle after the first grant.
- BL=1, si_vld=4'b1010, zo_rdy=1 -> zo_sel alternates 1,3,1,3. Requester 3 never waits more than 1 cycle.
- Lock release: requester 2 wins, sends 1 word, then drops si_vld while si_vld[0]=1 -> next grant goes to 0 in the same cycle, no idle cycle on zo. ptr search for the next winner starts at 3.
- Back-pressure: zo_rdy=0 for 3 cycles with zo_vld=1 -> zo_bus/zo_sel stable, si_rdy=0. On zo_rdy=1 the next word loads the same cycle and no data is lost or duplicated (scoreboard per requester).
- Random vld/rdy with N=3, BL=3 for 10k cycles -> per-requester in-order delivery, no requester starved for more than (N-1)*BL transfers.

Source files
------------

// File: rtl/zstr_pkg.sv
// Shared types and helpers for the z-stream arbiter slice: state encoding,
// index-width helper and the rotating-priority search.
package zstr_pkg;

  localparam int unsigned ZSTR_MAXN = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } zstr_arb_state_e;

  // Index width that stays at least one bit wide when n is 1.
  function automatic int unsigned zstr_nw(input int unsigned n);
    return (n < 2) ? 1 : unsigned'($clog2(n));
  endfunction

  // One-hot first requester found searching ptr, ptr+1, ... modulo n.
  function automatic logic [ZSTR_MAXN-1:0] zstr_rr_pick(
    input logic [ZSTR_MAXN-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [ZSTR_MAXN-1:0] res;
    logic                 found;
    int unsigned          idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ZSTR_MAXN; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[4:0]]) begin
        res[idx[4:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/zstr_reg.sv
// One-entry registered z-stream stage; accepts a new word whenever it is
// empty or its current word is being drained in the same cycle.
module zstr_reg
  import zstr_pkg::*;
#(
  parameter int unsigned     BW = 1,
  parameter logic [BW-1:0]   XZ = 'x
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          si_vld,
  input  logic [BW-1:0] si_bus,
  output logic          si_rdy,
  output logic          zo_vld,
  output logic [BW-1:0] zo_bus,
  input  logic          zo_rdy
);

  logic          vld_q, vld_d;
  logic [BW-1:0] bus_q, bus_d;
  logic          ld;

  always_comb begin
    ld    = ~vld_q | zo_rdy;
    vld_d = vld_q;
    bus_d = bus_q;
    if (ld) begin
      vld_d = si_vld;
      bus_d = si_vld ? si_bus : XZ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      bus_q <= XZ;
    end else begin
      vld_q <= vld_d;
      bus_q <= bus_d;
    end
  end

  assign si_rdy = ld;
  assign zo_vld = vld_q;
  assign zo_bus = bus_q;

endmodule

// File: rtl/zstr_arb.sv
// N-to-1 round-robin z-stream arbiter with optional burst lock, feeding a
// registered output stage so requester valid/bus never reach the drain combinationally.
module zstr_arb
  import zstr_pkg::*;
#(
  parameter int unsigned   N  = 4,
  parameter int unsigned   BW = 1,
  parameter logic [BW-1:0] XZ = 'x,
  parameter int unsigned   BL = 1,
  parameter int unsigned   NW = zstr_nw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    si_vld,
  input  logic [N*BW-1:0] si_bus,
  output logic [N-1:0]    si_rdy,
  output logic            zo_vld,
  output logic [BW-1:0]   zo_bus,
  output logic [NW-1:0]   zo_sel,
  input  logic            zo_rdy
);

  localparam int unsigned CW = zstr_nw(BL);

  zstr_arb_state_e      state_q, state_d;
  logic [NW-1:0]        ptr_q, ptr_d;
  logic [NW-1:0]        own_q, own_d;
  logic [NW-1:0]        sel_q, sel_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 ld;
  logic                 lock_hold;
  logic                 any_gnt;
  logic                 xfer;
  logic [NW-1:0]        start;
  logic [NW-1:0]        win;
  logic [N-1:0]         gnt;
  logic [ZSTR_MAXN-1:0] pick;
  logic [BW-1:0]        mux_bus;

  function automatic logic [NW-1:0] inc(input logic [NW-1:0] x);
    return (x == NW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // A lock whose owner went idle is dropped in the same cycle; the search
  // then resumes just after the owner so nobody waits an extra cycle.
  always_comb begin
    lock_hold = (state_q == LOCK) && si_vld[own_q];
    start     = (state_q == LOCK) ? inc(own_q) : ptr_q;
    pick      = zstr_rr_pick(ZSTR_MAXN'(si_vld), 32'(start), N);
    gnt       = pick[N-1:0];
    if (lock_hold) begin
      gnt        = '0;
      gnt[own_q] = 1'b1;
    end
    any_gnt = lock_hold | (|pick);
    win     = '0;
    mux_bus = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) begin
        win     = NW'(i);
        mux_bus = si_bus[i*BW +: BW];
      end
    end
    xfer   = ld & any_gnt;
    si_rdy = {N{ld}} & gnt;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (xfer) begin
      sel_d = win;
      if (lock_hold) begin
        if (cnt_q == CW'(BL - 1)) begin
          state_d = IDLE;
          ptr_d   = inc(own_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (BL == 1) begin
        state_d = IDLE;
        ptr_d   = inc(win);
      end else begin
        state_d = LOCK;
        own_d   = win;
        cnt_d   = CW'(1);
      end
    end else if (state_q == LOCK && !si_vld[own_q]) begin
      state_d = IDLE;
      ptr_d   = inc(own_q);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  zstr_reg #(
    .BW (BW),
    .XZ (XZ)
  ) u_reg (
    .clk    (clk),
    .rst    (rst),
    .si_vld (any_gnt),
    .si_bus (mux_bus),
    .si_rdy (ld),
    .zo_vld (zo_vld),
    .zo_bus (zo_bus),
    .zo_rdy (zo_rdy)
  );

  assign zo_sel = sel_q;

endmodule

// File: tb/tb_zstr_arb.sv
// Bench for zstr_arb: vector table on a burst-locked instance, alternation on a
// BL=1 instance, and a randomized scoreboard run on a 3-requester instance.
module tb_zstr_arb;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, BW=8, BL=2
  logic [3:0]  vld_a, rdy_a;
  logic [31:0] bus_a;
  logic        zv_a, zr_a;
  logic [7:0]  zb_a;
  logic [1:0]  zs_a;

  zstr_arb #(.N(4), .BW(8), .XZ(8'hA5), .BL(2)) u_a (
    .clk(clk), .rst(rst), .si_vld(vld_a), .si_bus(bus_a), .si_rdy(rdy_a),
    .zo_vld(zv_a), .zo_bus(zb_a), .zo_sel(zs_a), .zo_rdy(zr_a)
  );

  // Instance B: N=4, BW=8, BL=1
  logic [3:0]  vld_b, rdy_b;
  logic [31:0] bus_b;
  logic        zv_b, zr_b;
  logic [7:0]  zb_b;
  logic [1:0]  zs_b;

  zstr_arb #(.N(4), .BW(8), .XZ(8'hA5), .BL(1)) u_b (
    .clk(clk), .rst(rst), .si_vld(vld_b), .si_bus(bus_b), .si_rdy(rdy_b),
    .zo_vld(zv_b), .zo_bus(zb_b), .zo_sel(zs_b), .zo_rdy(zr_b)
  );

  // Instance C: N=3, BW=8, BL=3
  logic [2:0]  vld_c, rdy_c;
  logic [23:0] bus_c;
  logic        zv_c, zr_c;
  logic [7:0]  zb_c;
  logic [1:0]  zs_c;

  zstr_arb #(.N(3), .BW(8), .XZ(8'hA5), .BL(3)) u_c (
    .clk(clk), .rst(rst), .si_vld(vld_c), .si_bus(bus_c), .si_rdy(rdy_c),
    .zo_vld(zv_c), .zo_bus(zb_c), .zo_sel(zs_c), .zo_rdy(zr_c)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] x_rdy;
    logic       x_vld;
    logic [1:0] x_sel;
    logic [7:0] x_bus;
  } vec_t;

  vec_t tbl [26];

  logic [7:0] q_b [$];
  logic [7:0] q_c [3][$];
  logic [5:0] seq_c [3];
  int         wait_c [3];
  logic [2:0] xfer_c;
  logic [7:0] w8;
  logic [1:0] eb;

  initial begin
    tbl[0]  = {4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
    tbl[1]  = {4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'hA5};
    tbl[2]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[3]  = {4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h10};
    tbl[4]  = {4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[5]  = {4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h11};
    tbl[6]  = {4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[7]  = {4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
    tbl[8]  = {4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[9]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h13};
    tbl[10] = {4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[11] = {4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[12] = {4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[13] = {4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[14] = {4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[15] = {4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
    tbl[16] = {4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 8'hA5};
    tbl[17] = {4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
    tbl[18] = {4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[19] = {4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h13};
    tbl[20] = {4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[21] = {4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 8'hA5};
    tbl[22] = {4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 8'h10};
    tbl[23] = {4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 8'h12};
    tbl[24] = {4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[25] = {4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};

    rst   = 1'b1;
    vld_a = '0; zr_a = 1'b1; bus_a = {8'h13, 8'h12, 8'h11, 8'h10};
    vld_b = '0; zr_b = 1'b1; bus_b = {8'h23, 8'h22, 8'h21, 8'h20};
    vld_c = '0; zr_c = 1'b1; bus_c = '0;
    for (int i = 0; i < 3; i++) begin
      seq_c[i]  = '0;
      wait_c[i] = 0;
    end
    xfer_c = '0;

    #2;
    chk("rst_zo_vld", 32'(zv_a), 32'd0);
    chk("rst_zo_bus", 32'(zb_a), 32'hA5);
    chk("rst_zo_sel", 32'(zs_a), 32'd0);
    chk("rst_si_rdy", 32'(rdy_a), 32'd0);

    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      vld_a = tbl[k].vld;
      zr_a  = tbl[k].rdy;
      #1;
      chk($sformatf("vec%0d_si_rdy", k), 32'(rdy_a), 32'(tbl[k].x_rdy));
      chk($sformatf("vec%0d_zo_vld", k), 32'(zv_a), 32'(tbl[k].x_vld));
      chk($sformatf("vec%0d_zo_sel", k), 32'(zs_a), 32'(tbl[k].x_sel));
      chk($sformatf("vec%0d_zo_bus", k), 32'(zb_a), 32'(tbl[k].x_bus));
    end

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    vld_a = 4'b1111; zr_a = 1'b1;
    #1;
    chk("ar_grant", 32'(rdy_a), 32'b0010);
    @(negedge clk);
    #1;
    chk("ar_pre_vld", 32'(zv_a), 32'd1);
    chk("ar_pre_sel", 32'(zs_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_zo_vld", 32'(zv_a), 32'd0);
    chk("ar_zo_bus", 32'(zb_a), 32'hA5);
    chk("ar_zo_sel", 32'(zs_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_ptr0_grant", 32'(rdy_a), 32'b0001);
    chk("ar_post_vld", 32'(zv_a), 32'd0);
    @(negedge clk);
    vld_a = '0;

    // BL=1 alternation between requesters 1 and 3.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vld_b = (k < 10) ? 4'b1010 : 4'b0000;
      zr_b  = 1'b1;
      #1;
      if (zv_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_out", 32'(zv_b), 32'd0);
        end else begin
          w8 = q_b.pop_front();
          chk($sformatf("b%0d_zo_sel", k), 32'(zs_b), 32'(w8));
          chk($sformatf("b%0d_zo_bus", k), 32'(zb_b), 32'h20 + 32'(w8));
        end
      end
      if (k < 10) begin
        eb = (k % 2 == 1) ? 2'd3 : 2'd1;
        chk($sformatf("b%0d_si_rdy", k), 32'(rdy_b), 32'd1 << eb);
        q_b.push_back({6'd0, eb});
      end
    end
    chk("b_all_delivered", 32'(q_b.size()), 32'd0);

    // Random traffic on N=3, BL=3 with per-requester ordering and starvation bound.
    for (int cyc = 0; cyc < 10200; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (xfer_c[i]) vld_c[i] = 1'b0;
        if (!vld_c[i] && cyc < 10000 && $urandom_range(0, 2) != 0) begin
          w8 = {i[1:0], seq_c[i]};
          seq_c[i] = seq_c[i] + 6'd1;
          bus_c[i*8 +: 8] = w8;
          vld_c[i] = 1'b1;
          q_c[i].push_back(w8);
        end
      end
      zr_c = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      xfer_c = vld_c & rdy_c;
      for (int i = 0; i < 3; i++) begin
        if (xfer_c[i]) begin
          tests++;
          if (wait_c[i] > 6) begin
            fails++;
            $display("FAIL c_starve req%0d: waited %0d transfers, limit 6", i, wait_c[i]);
          end
          wait_c[i] = 0;
        end else if (vld_c[i] && (|xfer_c)) begin
          wait_c[i]++;
        end
      end
      if (zv_c && zr_c) begin
        if (zs_c > 2'd2 || q_c[zs_c].size() == 0) begin
          chk("c_unexpected_out", 32'(zs_c), 32'hFF);
        end else begin
          w8 = q_c[zs_c].pop_front();
          chk("c_data_order", 32'(zb_c), 32'(w8));
        end
      end
      if (cyc >= 10000 && vld_c == '0 && !zv_c) break;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("c_drained%0d", i), 32'(q_c[i].size()), 32'd0);
    chk("c_idle_vld", 32'(vld_c), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
